// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table self-test sequencer.
package tts_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} tts_state_t;

    // Golden 3-input majority: z=1 for rows 3, 5, 6, 7.
    localparam logic [7:0] MAJ3_TT = 8'hE8;

    function automatic int rows(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control/result bundle between the lab top level and the sequencer.
interface truth_table_sequencer_if
    import tts_pkg::*;
#(
    parameter int N_IN = 3
);
    localparam int ROWS = rows(N_IN);

    logic            start;
    logic            abort;
    logic            z_in;
    logic [N_IN-1:0] test_vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ROWS-1:0] observed;
    logic [ROWS-1:0] fail_map;

    modport master (
        input  start, abort, z_in,
        output test_vec, busy, done, pass, observed, fail_map
    );

    modport slave (
        output start, abort, z_in,
        input  test_vec, busy, done, pass, observed, fail_map
    );

endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// Per-row hold counter: counts 0..SETTLE_CYCLES and flags the sampling edge.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign expire = en && !clear && (cnt == LAST);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all input rows of the gate datapath, samples z after a settle window
// and compares the captured table against EXPECTED.
module truth_table_sequencer
    import tts_pkg::*;
#(
    parameter int                          N_IN          = 3,
    parameter int                          SETTLE_CYCLES = 2,
    parameter logic [(1 << N_IN)-1:0]      EXPECTED      = MAJ3_TT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    truth_table_sequencer_if.master  bus
);
    localparam int ROWS = rows(N_IN);
    localparam logic [N_IN:0] LAST_ROW = (N_IN + 1)'(ROWS - 1);

    tts_state_t      state, state_nxt;
    logic [N_IN:0]   row, row_nxt;
    logic [ROWS-1:0] obs_q, obs_nxt;
    logic [ROWS-1:0] fm_q, fm_nxt;
    logic            busy_q, done_q, pass_q;
    logic            load;
    logic            expire;

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (load || (state != RUN)),
        .en     ((state == RUN) && !bus.abort),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        row_nxt   = row;
        obs_nxt   = obs_q;
        fm_nxt    = fm_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    row_nxt   = '0;
                end else if (expire) begin
                    obs_nxt[row[N_IN-1:0]] = bus.z_in;
                    fm_nxt[row[N_IN-1:0]]  = bus.z_in ^ EXPECTED[row[N_IN-1:0]];
                    if (row == LAST_ROW) state_nxt = DONE;
                    else                 row_nxt   = row + 1'b1;
                end
            end
            DONE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    row_nxt   = '0;
                end else if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A fresh run always starts from row 0 with empty result maps.
        if (load) begin
            row_nxt = '0;
            obs_nxt = '0;
            fm_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row    <= '0;
            obs_q  <= '0;
            fm_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            row    <= row_nxt;
            obs_q  <= obs_nxt;
            fm_q   <= fm_nxt;
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
            pass_q <= (state_nxt == DONE) && (fm_nxt == '0);
        end
    end

    assign bus.test_vec = row[N_IN-1:0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.observed = obs_q;
    assign bus.fail_map = fm_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: a settle-2 and a settle-0 instance.
module tb_truth_table_sequencer;
    import tts_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(3)) b0 ();
    truth_table_sequencer_if #(.N_IN(3)) b1 ();

    truth_table_sequencer #(.N_IN(3), .SETTLE_CYCLES(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.master)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE_CYCLES(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    typedef struct {
        logic [7:0] obs;
        logic [7:0] fm;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mode = 0;
    logic sel = 1'b0;

    logic [2:0] cur_tv;
    logic       cur_busy, cur_done, cur_pass;
    logic [7:0] cur_obs, cur_fm;

    // 0: majority gate, 1: stuck-at-0, 2: stuck-at-1
    function automatic logic zf(input int m, input logic [2:0] v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return (a & b) | (a & c) | (b & c);
        endcase
    endfunction

    always_comb b0.z_in = zf(mode, b0.test_vec);
    always_comb b1.z_in = zf(mode, b1.test_vec);

    always_comb begin
        cur_tv   = sel ? b1.test_vec : b0.test_vec;
        cur_busy = sel ? b1.busy     : b0.busy;
        cur_done = sel ? b1.done     : b0.done;
        cur_pass = sel ? b1.pass     : b0.pass;
        cur_obs  = sel ? b1.observed : b0.observed;
        cur_fm   = sel ? b1.fail_map : b0.fail_map;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) b1.start = v;
        else     b0.start = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) b1.abort = v;
        else     b0.abort = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tv"},   cur_tv,   0);
        check({tag, "_busy"}, cur_busy, 0);
        check({tag, "_done"}, cur_done, 0);
        check({tag, "_pass"}, cur_pass, 0);
        check({tag, "_obs"},  cur_obs,  0);
        check({tag, "_fm"},   cur_fm,   0);
    endtask

    task automatic do_sweep(input int m, input int s, input int pulse_row);
        exp_t e, got_e;
        int   n;
        int   row;
        bit   pulsed;
        mode = m;
        e.obs = '0;
        for (int r = 0; r < 8; r++) e.obs[r] = zf(m, 3'(r));
        e.fm   = e.obs ^ 8'hE8;
        e.pass = (e.fm == 8'h00);
        e.lat  = 8 * (s + 1);
        sb.push_back(e);

        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        check("start_busy", cur_busy, 1);
        check("start_done", cur_done, 0);
        check("start_obs",  cur_obs,  0);
        check("start_fm",   cur_fm,   0);

        n = 0;
        pulsed = 1'b0;
        while (!cur_done && n < 200) begin
            row = n / (s + 1);
            check("tv_step", cur_tv, row);
            if (pulse_row >= 0 && row == pulse_row && !pulsed) begin
                pulsed = 1'b1;
                set_start(1'b1);
                @(posedge clk); #1 set_start(1'b0);
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end

        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got_e = sb.pop_front();
            check("latency",  n,        got_e.lat);
            check("observed", cur_obs,  got_e.obs);
            check("fail_map", cur_fm,   got_e.fm);
            check("pass",     cur_pass, got_e.pass);
            check("done_busy", cur_busy, 0);
            check("done_tv",  cur_tv,   7);
        end
    endtask

    initial begin
        int   n;
        logic seen_done;
        logic [7:0] part;

        b0.start = 1'b0; b0.abort = 1'b0;
        b1.start = 1'b0; b1.abort = 1'b0;

        // Power-on reset state
        #2;
        check_all_zero("por");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", cur_busy, 0);
        check("idle_done", cur_done, 0);

        // Golden, stuck-at-0 (start from DONE), stuck-at-1 with start pulsed at row 3
        do_sweep(0, 2, -1);
        do_sweep(1, 2, -1);
        do_sweep(2, 2, 3);

        // Asynchronous reset between clock edges
        @(negedge clk); #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", cur_busy, 0);

        // Abort while row 4 is driven
        mode = 0;
        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        n = 0;
        while (cur_tv != 3'd4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reach_row4", cur_tv, 4);
        set_abort(1'b1);
        @(posedge clk); #1 set_abort(1'b0);
        part = '0;
        for (int r = 0; r < 4; r++) part[r] = zf(0, 3'(r));
        check("abort_tv",   cur_tv,   0);
        check("abort_busy", cur_busy, 0);
        check("abort_done", cur_done, 0);
        check("abort_obs",  cur_obs,  part);

        // Abort from DONE
        do_sweep(0, 2, -1);
        set_abort(1'b1);
        @(posedge clk); #1 set_abort(1'b0);
        check("abort_done_state", cur_done, 0);
        check("abort_done_tv",    cur_tv,   0);

        // Zero-settle instance
        sel = 1'b1;
        do_sweep(0, 0, -1);
        do_sweep(1, 0, -1);

        // Reset at row 5 of a zero-settle sweep
        mode = 0;
        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        n = 0;
        while (cur_tv != 3'd5 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("s0_reach_row5", cur_tv, 5);
        rst_n = 1'b0;
        #1 check_all_zero("s0_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (cur_done) seen_done = 1'b1;
        end
        check("s0_no_done", seen_done, 0);
        check("s0_idle_busy", cur_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
